// File: rtl/img_stream_reader.sv
// Image stream reader: pulls pixels from the image-source handshake into a
// FIFO. The HPS reads the FIFO, status and a pixel counter through an
// Avalon-MM register window.
module img_stream_reader #(
  parameter int PIX_W = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             get_next_pix,
  input  logic             pix_rdy,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             img_done,
  output logic             cpu_rdy,
  output logic [3:0]       out_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_REQ  = 4'd1,
    ST_WAIT = 4'd2,
    ST_DONE = 4'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             spurious_q, spurious_d;
  logic             get_next_pix_q, get_next_pix_d;
  logic             cpu_rdy_q, cpu_rdy_d;
  logic [31:0]      readdata_q, readdata_d;

  logic        ctrl_wr, clear, start, data_rd;
  logic        fifo_empty, fifo_full, push, pop, restart;
  logic [7:0]  level8;
  logic [31:0] status_w;
  logic        unused_wdata;

  assign ctrl_wr    = avs_write && (avs_address == 3'd0);
  assign clear      = ctrl_wr && avs_writedata[1];
  assign start      = ctrl_wr && avs_writedata[0] && !avs_writedata[1];
  assign data_rd    = avs_read && (avs_address == 3'd2);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == DEPTH_L);
  assign pop        = data_rd && !fifo_empty;
  assign level8     = 8'(level_q);
  assign status_w   = {16'd0, level8, 3'd0, spurious_q, underflow_q,
                       (state_q == ST_DONE), fifo_full, fifo_empty};
  assign unused_wdata = ^avs_writedata[31:2];

  // Next-state logic: request sequencing, FIFO bookkeeping, flags and read mux.
  always_comb begin
    state_d        = state_q;
    get_next_pix_d = 1'b0;
    count_d        = count_q;
    underflow_d    = underflow_q;
    spurious_d     = spurious_q;
    readdata_d     = readdata_q;
    push           = 1'b0;
    restart        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (img_done) begin
          state_d = ST_DONE;
        end else if (level_q < DEPTH_L) begin
          get_next_pix_d = 1'b1;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pix_rdy) begin
          push    = 1'b1;
          state_d = img_done ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        if (start) begin
          restart = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      count_d     = '0;
      underflow_d = 1'b0;
      spurious_d  = 1'b0;
    end
    if (push) begin
      count_d = count_d + CNT_W'(1);
    end
    if (data_rd && fifo_empty) begin
      underflow_d = 1'b1;
    end
    if (pix_rdy && (state_q != ST_WAIT)) begin
      spurious_d = 1'b1;
    end

    if (avs_read) begin
      case (avs_address)
        3'd1:    readdata_d = status_w;
        3'd2:    readdata_d = fifo_empty ? 32'd0 : 32'(mem_q[rd_ptr_q]);
        3'd3:    readdata_d = 32'(count_q);
        default: readdata_d = 32'd0;
      endcase
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (clear) begin
      state_d        = ST_IDLE;
      get_next_pix_d = 1'b0;
      count_d        = '0;
      underflow_d    = 1'b0;
      spurious_d     = 1'b0;
      readdata_d     = 32'd0;
      push           = 1'b0;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      level_d        = '0;
    end

    cpu_rdy_d = (level_d != '0);
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      count_q        <= '0;
      underflow_q    <= 1'b0;
      spurious_q     <= 1'b0;
      get_next_pix_q <= 1'b0;
      cpu_rdy_q      <= 1'b0;
      readdata_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      count_q        <= count_d;
      underflow_q    <= underflow_d;
      spurious_q     <= spurious_d;
      get_next_pix_q <= get_next_pix_d;
      cpu_rdy_q      <= cpu_rdy_d;
      readdata_q     <= readdata_d;
    end
  end

  // Pixel storage; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pixel_data;
    end
  end

  assign avs_readdata = readdata_q;
  assign get_next_pix = get_next_pix_q;
  assign cpu_rdy      = cpu_rdy_q;
  assign out_state    = state_q;

endmodule

// File: tb/tb_img_stream_reader.sv
// Testbench for img_stream_reader: randomized source/CPU traffic checked
// every cycle against a queue-based reference model, plus directed literals.
module tb_img_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        get_next_pix;
  logic        pix_rdy = 1'b0;
  logic [23:0] pixel_data = 24'd0;
  logic        img_done = 1'b0;
  logic        cpu_rdy;
  logic [3:0]  out_state;

  // small instance signals
  logic [2:0]  s_address = 3'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        s_gnp;
  logic        s_pix_rdy = 1'b0;
  logic [7:0]  s_pixel = 8'd0;
  logic        s_done = 1'b0;
  logic        s_cpu_rdy;
  logic [3:0]  s_state;

  int tests = 0;
  int fails = 0;

  img_stream_reader #(.PIX_W(24), .DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .get_next_pix(get_next_pix), .pix_rdy(pix_rdy), .pixel_data(pixel_data),
    .img_done(img_done), .cpu_rdy(cpu_rdy), .out_state(out_state)
  );

  img_stream_reader #(.PIX_W(8), .DEPTH(4), .CNT_W(8)) dut_small (
    .clk(clk), .reset(reset),
    .avs_address(s_address), .avs_read(s_read), .avs_write(s_write),
    .avs_writedata(s_writedata), .avs_readdata(s_readdata),
    .get_next_pix(s_gnp), .pix_rdy(s_pix_rdy), .pixel_data(s_pixel),
    .img_done(s_done), .cpu_rdy(s_cpu_rdy), .out_state(s_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_DONE = 3;
  localparam int MDEPTH = 16;
  logic [31:0] m_q[$];
  int          m_phase = P_IDLE;
  logic [31:0] m_cnt = 0;
  logic        m_under = 0, m_spur = 0, m_gnp = 0, m_rdy = 0, m_rvalid = 0;
  logic [31:0] m_rdata = 0;

  task automatic modelStep();
    logic is_ctrl, do_clear, do_start;
    int pre_len, pre_phase;
    logic [31:0] status;
    is_ctrl  = avs_write && (avs_address == 3'd0);
    do_clear = is_ctrl && avs_writedata[1];
    do_start = is_ctrl && avs_writedata[0] && !avs_writedata[1];
    m_rvalid = avs_read;
    if (do_clear) begin
      m_q.delete(); m_phase = P_IDLE; m_cnt = 0; m_under = 0; m_spur = 0;
      m_gnp = 0; m_rdy = 0; m_rdata = 0; m_rvalid = 1;
      return;
    end
    pre_len   = m_q.size();
    pre_phase = m_phase;
    status = 32'(pre_len == 0) | (32'(pre_len == MDEPTH) << 1) | (32'(pre_phase == P_DONE) << 2)
           | (32'(m_under) << 3) | (32'(m_spur) << 4) | (32'(pre_len) << 8);
    if (avs_read) begin
      case (avs_address)
        3'd1: m_rdata = status;
        3'd2: begin
          if (pre_len > 0) m_rdata = m_q.pop_front();
          else begin m_rdata = 0; m_under = 1; end
        end
        3'd3: m_rdata = m_cnt;
        default: m_rdata = 0;
      endcase
    end
    m_gnp = 0;
    if (pre_phase == P_IDLE || pre_phase == P_DONE) begin
      if (do_start) begin m_cnt = 0; m_under = 0; m_spur = 0; m_phase = P_REQ; end
    end else if (pre_phase == P_REQ) begin
      if (img_done) m_phase = P_DONE;
      else if (pre_len < MDEPTH) begin m_gnp = 1; m_phase = P_WAIT; end
    end else begin
      if (pix_rdy) begin
        m_q.push_back(32'(pixel_data));
        m_cnt = m_cnt + 1;
        m_phase = img_done ? P_DONE : P_REQ;
      end
    end
    if (pix_rdy && pre_phase != P_WAIT) m_spur = 1;
    m_rdy = (m_q.size() != 0);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete(); m_phase = P_IDLE; m_cnt = 0; m_under = 0; m_spur = 0;
      m_gnp = 0; m_rdy = 0; m_rdata = 0; m_rvalid = 1;
    end else begin
      modelStep();
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    checkOutput("cyc_get_next_pix", 32'(get_next_pix), 32'(m_gnp));
    checkOutput("cyc_cpu_rdy", 32'(cpu_rdy), 32'(m_rdy));
    checkOutput("cyc_out_state", 32'(out_state), 32'(m_phase));
    if (m_rvalid) checkOutput("cyc_readdata", avs_readdata, m_rdata);
  end

  // Request counter for the main instance.
  int req_count = 0;
  always @(negedge clk) if (get_next_pix) req_count++;

  // ---------------- image source responder ----------------
  int  restart_req = 0, restart_seen = 0, spur_req = 0, spur_seen = 0;
  int  done_at = 0, max_delay = 0;
  bit  spur_rand = 0;
  bit  pending = 0;
  int  delay = 0, sent = 0;
  logic [23:0] next_pix = 24'd1;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      pix_rdy = 0; img_done = 0; pending = 0; sent = 0; next_pix = 24'd1;
    end else begin
      pix_rdy = 0;
      if (restart_req != restart_seen) begin
        restart_seen = restart_req;
        sent = 0; next_pix = 24'd1; img_done = 0; pending = 0;
      end
      if (pending) begin
        if (delay == 0) begin
          pix_rdy = 1; pixel_data = next_pix; next_pix = next_pix + 24'd1;
          sent++; pending = 0;
          if (done_at != 0 && sent == done_at) img_done = 1;
        end else delay--;
      end else if (get_next_pix) begin
        pending = 1; delay = $urandom_range(0, max_delay);
      end else if (spur_req != spur_seen) begin
        spur_seen = spur_req; pix_rdy = 1; pixel_data = 24'($urandom);
      end else if (spur_rand && $urandom_range(0, 29) == 0) begin
        pix_rdy = 1; pixel_data = 24'($urandom);
      end
    end
  end

  // ---------------- CPU tasks ----------------
  task automatic cpuRead(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); avs_address = a; avs_read = 1;
    @(negedge clk); avs_read = 0; d = avs_readdata;
  endtask

  task automatic cpuWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); avs_address = a; avs_writedata = d; avs_write = 1;
    @(negedge clk); avs_write = 0;
  endtask

  task automatic restartSource();
    restart_req++;
    repeat (2) @(negedge clk);
  endtask

  task automatic smallRead(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk); s_address = a; s_read = 1;
    @(negedge clk); s_read = 0; d = s_readdata;
  endtask

  task automatic smallTest();
    logic [31:0] d;
    int n;
    @(negedge clk); s_address = 0; s_writedata = 32'h1; s_write = 1;
    @(negedge clk); s_write = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!s_gnp && n < 20) begin @(negedge clk); n++; end
      if (n == 20) checkOutput("small_request_timeout", 0, 1);
      @(negedge clk); s_pix_rdy = 1; s_pixel = (i == 0) ? 8'hAB : 8'(8'h10 + i);
      @(negedge clk); s_pix_rdy = 0;
    end
    repeat (3) @(negedge clk);
    checkOutput("small_no_request_when_full", 32'(s_gnp), 0);
    checkOutput("small_cpu_rdy", 32'(s_cpu_rdy), 1);
    smallRead(3'd1, d); checkOutput("small_status_full", d, 32'h0000_0402);
    smallRead(3'd2, d); checkOutput("small_data_ab", d, 32'h0000_00AB);
  endtask

  // Randomized CPU traffic while the responder feeds pixels.
  task automatic applyStimulus(input int iters);
    logic [31:0] d;
    int r;
    for (int i = 0; i < iters; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) @(negedge clk);
      else if (r < 85) begin
        case ($urandom_range(0, 4))
          0: cpuRead(3'd1, d);
          1, 2: cpuRead(3'd2, d);
          3: cpuRead(3'd3, d);
          default: cpuRead(3'd5, d);
        endcase
      end else if (r < 89) cpuWrite(3'd0, {30'($urandom), 2'b01});
      else if (r == 89) cpuWrite(3'd0, 32'h3);
      else if (r < 95) cpuWrite(3'($urandom_range(1, 7)), $urandom);
      else @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int base, n;
    #2 reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;

    smallTest();

    cpuRead(3'd1, d); checkOutput("status_after_reset", d, 32'h0000_0001);

    // Fill the FIFO with no CPU reads.
    max_delay = 0; done_at = 0; restartSource();
    base = req_count;
    cpuWrite(3'd0, 32'h1);
    repeat (60) @(negedge clk);
    checkOutput("fill_requests", 32'(req_count - base), 16);
    cpuRead(3'd1, d); checkOutput("status_full", d, 32'h0000_1002);
    cpuRead(3'd3, d); checkOutput("count_16", d, 32'd16);
    cpuRead(3'd2, d); checkOutput("first_pixel", d, 32'h0000_0001);
    repeat (10) @(negedge clk);
    checkOutput("refill_requests", 32'(req_count - base), 17);
    cpuRead(3'd1, d); checkOutput("status_full_again", d, 32'h0000_1002);

    // img_done together with the third pixel.
    cpuWrite(3'd0, 32'h2);
    cpuRead(3'd1, d); checkOutput("status_after_clear", d, 32'h0000_0001);
    done_at = 3; restartSource();
    cpuWrite(3'd0, 32'h1);
    repeat (20) @(negedge clk);
    cpuRead(3'd1, d); checkOutput("status_done3", d, 32'h0000_0304);
    cpuRead(3'd2, d); checkOutput("done_pix1", d, 32'd1);
    cpuRead(3'd2, d); checkOutput("done_pix2", d, 32'd2);
    cpuRead(3'd2, d); checkOutput("done_pix3", d, 32'd3);
    cpuRead(3'd2, d); checkOutput("underflow_read", d, 32'd0);
    cpuRead(3'd1, d); checkOutput("status_underflow", d, 32'h0000_000D);

    // Spurious pix_rdy while idle.
    cpuWrite(3'd0, 32'h2);
    spur_req++;
    repeat (3) @(negedge clk);
    cpuRead(3'd1, d); checkOutput("status_spurious", d, 32'h0000_0011);
    cpuWrite(3'd0, 32'h2);
    cpuRead(3'd1, d); checkOutput("status_spur_cleared", d, 32'h0000_0001);

    // Randomized rounds.
    for (int rnd = 0; rnd < 8; rnd++) begin
      max_delay = $urandom_range(0, 3);
      done_at = $urandom_range(4, 40);
      spur_rand = 1;
      restartSource();
      cpuWrite(3'd0, 32'h1);
      applyStimulus(200);
    end
    spur_rand = 0;

    // Reset asserted mid-WAIT with 5 pixels buffered.
    cpuWrite(3'd0, 32'h2);
    max_delay = 3; done_at = 0; restartSource();
    cpuWrite(3'd0, 32'h1);
    n = 0;
    while (!(m_q.size() == 5 && m_phase == P_WAIT) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n == 200) checkOutput("midwait_reached", 0, 1);
    #2 reset = 1;
    #1;
    checkOutput("async_rst_readdata", avs_readdata, 32'd0);
    checkOutput("async_rst_gnp", 32'(get_next_pix), 0);
    checkOutput("async_rst_cpu_rdy", 32'(cpu_rdy), 0);
    checkOutput("async_rst_state", 32'(out_state), 0);
    @(negedge clk); reset = 0;
    cpuRead(3'd1, d); checkOutput("status_after_midwait_reset", d, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
